// File: rtl/calib_pattern_sequencer.sv
// Structured-light sequencer: paints each LED red/green by one code bit per pass (MSB first)
// and steps the calibration FSM through one capture per pass.
`timescale 1ns/1ps

// state        | meaning
// IDLE         | waiting for a start edge, colours black
// SET_PATTERN  | latch pass number into the displayed pattern
// FLUSH1       | first strand_done; strand may still hold the old pattern
// FLUSH2       | second strand_done; strand now fully shows the pattern
// ARM          | one-cycle increment_id pulse
// HOLD_VALID   | displayed_frame_valid high until cal FSM reaches WAIT_FOR_CAM
// WAIT_CAPTURE | waiting for CAPTURE_FRAME
// WAIT_RETURN  | waiting for cal FSM to return to IDLE
// NEXT         | advance pass or finish
// DONE         | sequence complete, colours black
module calib_pattern_sequencer #(
   parameter int NUM_LEDS          = 50,
   parameter int LED_ADDRESS_WIDTH = 10,
   parameter int ID_OFFSET         = 1,
   parameter int INDEX_WIDTH       = $clog2(NUM_LEDS),
   localparam int BIT_W            = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1
) (
   input  logic                   clk_pixel,
   input  logic                   rst,
   input  logic                   start_in,
   input  logic                   abort_in,
   input  logic [2:0]             cal_state_in,
   input  logic                   led_request_in,
   input  logic [INDEX_WIDTH-1:0] led_index_in,
   input  logic                   strand_done_in,
   output logic [7:0]             red_out,
   output logic [7:0]             green_out,
   output logic [7:0]             blue_out,
   output logic                   color_valid_out,
   output logic                   increment_id_out,
   output logic                   should_overwrite_out,
   output logic                   displayed_frame_valid_out,
   output logic [BIT_W-1:0]       bit_idx_out,
   output logic                   busy_out,
   output logic                   done_out
);

   typedef enum logic [3:0] {
      S_IDLE, S_SET_PATTERN, S_FLUSH1, S_FLUSH2, S_ARM,
      S_HOLD_VALID, S_WAIT_CAPTURE, S_WAIT_RETURN, S_NEXT, S_DONE
   } state_t;

   localparam logic [2:0] CAL_IDLE    = 3'd0;
   localparam logic [2:0] CAL_WAITCAM = 3'd2;
   localparam logic [2:0] CAL_CAPTURE = 3'd4;
   localparam int CODE_W = LED_ADDRESS_WIDTH + 1;
   localparam logic [BIT_W-1:0] LAST_PASS = BIT_W'(LED_ADDRESS_WIDTH - 1);

   if (NUM_LEDS - 1 + ID_OFFSET >= (1 << LED_ADDRESS_WIDTH)) begin : g_code_overflow
      $error("calib_pattern_sequencer: LED codes do not fit in LED_ADDRESS_WIDTH bits");
   end

   state_t           state_q, state_d;
   logic [BIT_W-1:0] pass_q, pass_d;
   logic [BIT_W-1:0] pattern_q, pattern_d;
   logic             grace_q, grace_d;
   logic             start_prev_q;
   logic             start_rise;
   logic             done_d;
   logic             busy_d;

   logic [CODE_W-1:0] code;
   logic [CODE_W-1:0] bit_mask;
   logic              code_bit;
   logic              in_range;
   logic              black;

   always_comb begin
      state_d    = state_q;
      pass_d     = pass_q;
      pattern_d  = pattern_q;
      grace_d    = grace_q;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      start_rise = start_in & ~start_prev_q;

      if (abort_in) begin
         state_d = S_IDLE;
         pass_d  = '0;
         grace_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_rise) begin
                  state_d = S_SET_PATTERN;
                  pass_d  = '0;
               end
            end
            S_SET_PATTERN: begin
               pattern_d = pass_q;
               state_d   = S_FLUSH1;
            end
            S_FLUSH1: if (strand_done_in) state_d = S_FLUSH2;
            S_FLUSH2: if (strand_done_in) state_d = S_ARM;
            S_ARM: begin
               grace_d = 1'b1;
               state_d = S_HOLD_VALID;
            end
            // The cal FSM is still IDLE the cycle after the pulse, so that cycle is not judged.
            S_HOLD_VALID: begin
               if (grace_q) begin
                  grace_d = 1'b0;
               end else if (cal_state_in == CAL_IDLE) begin
                  state_d = S_SET_PATTERN;
               end else if (cal_state_in == CAL_WAITCAM) begin
                  state_d = S_WAIT_CAPTURE;
               end
            end
            S_WAIT_CAPTURE: begin
               if (cal_state_in == CAL_IDLE) begin
                  state_d = S_SET_PATTERN;
               end else if (cal_state_in == CAL_CAPTURE) begin
                  state_d = S_WAIT_RETURN;
               end
            end
            S_WAIT_RETURN: if (cal_state_in == CAL_IDLE) state_d = S_NEXT;
            S_NEXT: begin
               if (pass_q == LAST_PASS) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  state_d = S_SET_PATTERN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   // MSB first: pass p shows code bit (LED_ADDRESS_WIDTH-1-p).
   always_comb begin
      code     = CODE_W'(led_index_in) + CODE_W'(ID_OFFSET);
      bit_mask = CODE_W'(1) << (LAST_PASS - pattern_q);
      code_bit = |(code & bit_mask);
      in_range = {1'b0, led_index_in} < (INDEX_WIDTH + 1)'(NUM_LEDS);
      black    = abort_in || !in_range || (state_q == S_IDLE) || (state_q == S_DONE);
   end

   assign blue_out = 8'd0;

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         state_q                   <= S_IDLE;
         pass_q                    <= '0;
         pattern_q                 <= '0;
         grace_q                   <= 1'b0;
         start_prev_q              <= 1'b0;
         increment_id_out          <= 1'b0;
         displayed_frame_valid_out <= 1'b0;
         should_overwrite_out      <= 1'b0;
         busy_out                  <= 1'b0;
         done_out                  <= 1'b0;
         bit_idx_out               <= '0;
         color_valid_out           <= 1'b0;
         red_out                   <= 8'd0;
         green_out                 <= 8'd0;
      end else begin
         state_q                   <= state_d;
         pass_q                    <= pass_d;
         pattern_q                 <= pattern_d;
         grace_q                   <= grace_d;
         start_prev_q              <= start_in;
         increment_id_out          <= (state_d == S_ARM);
         displayed_frame_valid_out <= (state_d == S_HOLD_VALID);
         should_overwrite_out      <= busy_d && (pass_d == '0);
         busy_out                  <= busy_d;
         done_out                  <= done_d;
         bit_idx_out               <= pass_d;
         color_valid_out           <= led_request_in;
         if (led_request_in && !black) begin
            red_out   <= code_bit ? 8'd0 : 8'd255;
            green_out <= code_bit ? 8'd255 : 8'd0;
         end else begin
            red_out   <= 8'd0;
            green_out <= 8'd0;
         end
      end
   end

endmodule
